bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side companion to the team's single-port BlockRAM (1-cycle registered read, no read enable).
- On a START command it sweeps LEN consecutive words from BASE, issuing one address per cycle to the RAM port.
- Returned words are presented as a valid/ready stream.
- Read latency and downstream backpressure are absorbed in a 2-entry output buffer, so the stream runs at full rate (1 word/cycle) when DO_READY is held high.

Parameters:
- ADDR_WIDTH, 1, RAM address width; must match the attached BlockRAM.
- DATA_WIDTH, 1, RAM word width; must match the attached BlockRAM.

Ports:
- CLK  in  1  clock; all logic on posedge
- RESETN  in  1  synchronous active-low reset
- START  in  1  command strobe; sampled only when BUSY=0
- BASE  in  ADDR_WIDTH  first word address, captured with START
- LEN  in  ADDR_WIDTH+1  word count (0..2**ADDR_WIDTH), captured with START
- BUSY  out  1  high from the cycle after an accepted START until the cycle DONE pulses
- DONE  out  1  one-cycle pulse when the last word has been accepted downstream
- RAM_ADDR  out  ADDR_WIDTH  address to the BlockRAM ADDR input; the BlockRAM WE is held low by the integrator
- RAM_DO  in  DATA_WIDTH  BlockRAM DO; valid one cycle after RAM_ADDR
- DO_VALID  out  1  output word valid
- DO_DATA  out  DATA_WIDTH  output word
- DO_READY  in  1  downstream accepts the word when DO_VALID and DO_READY are both high

Behaviour:
- Reset (RESETN=0 at posedge):
  - BUSY=0, DONE=0, DO_VALID=0, RAM_ADDR=0.
  - Buffer occupancy, in-flight flag, issue counter and accept counter all cleared.
- Reset mid-operation:
  - Abandons the transfer immediately.
  - No DONE pulse; any in-flight RAM word is discarded.
- States:
  - IDLE:
    - START=1 and LEN≠0 → RUN. Capture BASE into the issue address; load LEN into the issue and accept counters.
    - START=1 and LEN=0 → DONE_ST.
  - RUN:
    - An issue occurs when issue counter ≠ 0 and (occupancy + inflight) < 2, or = 2 with a pop in the same cycle.
    - On an issue: RAM_ADDR ← issue address; issue address increments modulo 2**ADDR_WIDTH (wrap from all-ones to 0 is legal); issue counter decrements; inflight ← 1 for the next cycle.
    - When inflight=1, RAM_DO is pushed into the buffer that cycle.
    - Each pop (DO_VALID & DO_READY) decrements the accept counter.
    - When the accept counter reaches 0 (last pop) → DONE_ST.
  - DONE_ST: DONE=1 for exactly one cycle; BUSY drops in the same cycle; → IDLE.
- START while BUSY=1 is ignored; BASE/LEN are not re-sampled.
- Latency:
  - START at cycle 0 → first RAM_ADDR at cycle 1 → RAM_DO at cycle 2 → DO_VALID=1 at cycle 2.
  - The buffer's first slot is combinationally bypassed when empty: DO_DATA = RAM_DO while inflight=1 and occupancy=0.
  - DONE pulses the cycle after the last pop.
- Throughput: with DO_READY held high, one word per cycle and no bubbles after the first.
- Buffer:
  - 2-entry FIFO; push and pop in the same cycle are allowed.
  - The issue rule guarantees no overflow; an overflow is an assertion failure in simulation.
  - DO_DATA is stable while DO_VALID=1 and DO_READY=0.
- RAM_ADDR holds its last value when no issue occurs. Stale RAM_DO returned for a non-issue cycle is never pushed, because inflight gates the push.
- LEN=2**ADDR_WIDTH: reads the whole RAM exactly once, wrapping if BASE≠0.
- Widths: counters are ADDR_WIDTH+1 bits; the address adder is ADDR_WIDTH bits, with the carry dropped.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, DONE_ST}
  - constant BUF_DEPTH=2
  - a helper computing the counter width as ADDR_WIDTH+1
- One natural sub-module: stream_skid_fifo2 (2-entry valid/ready FIFO with empty-bypass), reusable by other RAM-facing blocks.
- Benches pair the reader with the existing BlockRAM, preloaded via its init file.

Test Plan:
- ADDR_WIDTH=4, RAM[i]=i+0x10, START with BASE=3, LEN=5, DO_READY=1 → DO_DATA 0x13,0x14,0x15,0x16,0x17 on cycles 2-6; DONE at cycle 7; BUSY high cycles 1-6.
- BASE=14, LEN=4, DO_READY=1 → 0x1E,0x1F,0x10,0x11 (address wrap); exactly 4 pops, then DONE.
- BASE=0, LEN=6, DO_READY toggling 1,0,0,1,1,0,… → all 6 words in order, none dropped or duplicated; DO_DATA held stable while stalled.
- LEN=0 → no DO_VALID; DONE one cycle after START; BUSY low throughout.
- START again at cycle 3 of a LEN=8 transfer with BASE=9 → ignored; stream still 0x10..0x17 from BASE=0.
- RESETN=0 for one cycle mid-stream (after 2 pops of LEN=8) → next cycle DO_VALID=0, BUSY=0, no DONE; a fresh START with BASE=5, LEN=1 yields a single 0x15 then DONE.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// bram_stream_reader_pkg
// Shared types and constants for the BlockRAM stream reader and its output
// buffer.
//   state_t    : reader FSM state encoding (also exported on the debug port)
//   BUF_DEPTH  : number of words the output buffer can hold
//   cnt_width  : width of the issue/accept counters for a given address width
// ---------------------------------------------------------------------------
package bram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

  // Counters must hold 0..2**addr_width inclusive, hence one extra bit.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/stream_skid_fifo2.sv
// ---------------------------------------------------------------------------
// stream_skid_fifo2
// Two-entry valid/ready FIFO with a combinational bypass when empty, so a
// word pushed into an empty FIFO is visible on the output in the same cycle.
//
// Handshake: a word leaves when o_valid && i_ready at posedge i_clk. Once
// o_valid is high it stays high, with o_data unchanged, until accepted.
// The producer must never push while two words are held unless a pop
// happens in the same cycle.
//
// Ports
//   i_clk, i_resetn : clock, synchronous active-low reset
//   i_push          : i_push_data is written this cycle
//   i_push_data     : word to write
//   o_valid/o_data  : head of queue (or bypassed push word when empty)
//   i_ready         : consumer accepts the head word
//   o_count         : number of words held in the registers (0..2)
// ---------------------------------------------------------------------------
module stream_skid_fifo2
  import bram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem0;   // head slot
  logic [WIDTH-1:0] r_mem1;   // second slot
  logic [1:0]       r_count;
  logic             w_pop;

  // Empty FIFO forwards the incoming word directly.
  assign o_valid = (r_count != 2'd0) || i_push;
  assign o_data  = (r_count == 2'd0) ? i_push_data : r_mem0;
  assign w_pop   = o_valid && i_ready;
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_count <= 2'd0;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          // push with pop is a pure bypass: nothing is stored
          if (i_push && !w_pop) begin
            r_mem0  <= i_push_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && w_pop) begin
            r_mem0 <= i_push_data;
          end else if (i_push) begin
            r_mem1  <= i_push_data;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_mem0 <= r_mem1;
            if (i_push) begin
              r_mem1 <= i_push_data;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_resetn)
    !((r_count == 2'(BUF_DEPTH)) && i_push && !w_pop));

endmodule

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
// Sweeps i_len consecutive words of a 1-cycle-latency BlockRAM starting at
// i_base and presents them as a valid/ready stream at up to one word/cycle.
//
// Stream handshake: a word transfers when o_do_valid && i_do_ready at
// posedge i_clk; o_do_valid/o_do_data hold until the word is accepted.
//
// Ports
//   i_clk, i_resetn : clock, synchronous active-low reset
//   i_start         : command strobe, only honoured when idle
//   i_base, i_len   : first address and word count (0..2**ADDR_WIDTH)
//   o_busy          : transfer in progress
//   o_done          : one-cycle pulse after the last word is accepted
//   o_ram_addr      : BlockRAM address
//   i_ram_do        : BlockRAM read data (one cycle after o_ram_addr)
//   o_do_valid, o_do_data, i_do_ready : output stream
//   o_state         : FSM state, for debug visibility
// ---------------------------------------------------------------------------
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_do,
  output logic                  o_do_valid,
  output logic [DATA_WIDTH-1:0] o_do_data,
  input  logic                  i_do_ready,
  output state_t                o_state
);

  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_ZERO = '0;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [ADDR_WIDTH-1:0] r_iss_addr;  // next address to issue
  logic [CW-1:0]         r_iss_cnt;   // addresses still to issue
  logic [CW-1:0]         r_acc_cnt;   // words still to be accepted downstream
  // r_addr_vld: o_ram_addr carries a requested address this cycle.
  // r_inflight: i_ram_do carries the corresponding word this cycle.
  logic                  r_addr_vld;
  logic                  r_inflight;

  logic                  w_pop;
  logic [1:0]            w_buf_count;
  logic [2:0]            w_outstanding;
  logic                  w_issue;

  stream_skid_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_push      (r_inflight),
    .i_push_data (i_ram_do),
    .o_valid     (o_do_valid),
    .o_data      (o_do_data),
    .i_ready     (i_do_ready),
    .o_count     (w_buf_count)
  );

  assign w_pop = o_do_valid && i_do_ready;

  // Every word already requested (address on the RAM port, data on RAM_DO,
  // or sitting in the buffer) owns a buffer slot. A new address may issue
  // only if a slot is free, or one is being freed by a pop this cycle.
  assign w_outstanding = {2'b00, r_addr_vld} + {2'b00, r_inflight} + {1'b0, w_buf_count};
  assign w_issue = (r_state == RUN) && (r_iss_cnt != CNT_ZERO) &&
                   ((w_outstanding < 3'(BUF_DEPTH)) ||
                    ((w_outstanding == 3'(BUF_DEPTH)) && w_pop));

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ram_addr <= '0;
      r_iss_addr <= '0;
      r_iss_cnt  <= '0;
      r_acc_cnt  <= '0;
      r_addr_vld <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= r_addr_vld;
      r_addr_vld <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (i_len != CNT_ZERO) begin
              // First address goes out on the accepting edge itself.
              r_state    <= RUN;
              r_busy     <= 1'b1;
              r_ram_addr <= i_base;
              r_addr_vld <= 1'b1;
              r_iss_addr <= i_base + ADDR_ONE;
              r_iss_cnt  <= i_len - CNT_ONE;
              r_acc_cnt  <= i_len;
            end else begin
              r_state <= DONE_ST;
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_ram_addr <= r_iss_addr;
            r_iss_addr <= r_iss_addr + ADDR_ONE;  // wraps, carry dropped
            r_iss_cnt  <= r_iss_cnt - CNT_ONE;
            r_addr_vld <= 1'b1;
          end
          if (w_pop) begin
            r_acc_cnt <= r_acc_cnt - CNT_ONE;
            if (r_acc_cnt == CNT_ONE) begin
              r_state <= DONE_ST;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_ram_addr = r_ram_addr;
  assign o_state    = r_state;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;
  import bram_stream_reader_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NW = 2 ** AW;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, do_valid;
  logic          do_ready = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do = '0;
  logic [DW-1:0] do_data;
  state_t        dbg_state;

  always #5 clk = ~clk;

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .i_start    (start),
    .i_base     (base),
    .i_len      (len),
    .o_busy     (busy),
    .o_done     (done),
    .o_ram_addr (ram_addr),
    .i_ram_do   (ram_do),
    .o_do_valid (do_valid),
    .o_do_data  (do_data),
    .i_do_ready (do_ready),
    .o_state    (dbg_state)
  );

  // BlockRAM stand-in: registered read, no enable, write port unused.
  logic [DW-1:0] mem [NW];
  always @(posedge clk) ram_do <= mem[ram_addr];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Expected stream for a transfer: mem[(base + k) mod 2**AW], k = 0..len-1.
  logic [DW-1:0] exp_q[$];
  int            pops = 0;

  task automatic model_load(input int b, input int l);
    for (int k = 0; k < l; k++) exp_q.push_back(mem[(b + k) % NW]);
  endtask

  // Monitor: ordered data, stall stability, DONE one cycle after last pop.
  initial begin
    bit            stalled_prev = 0;
    bit            done_next = 0;
    logic [DW-1:0] held = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stalled_prev = 0;
        done_next = 0;
      end else begin
        if (done_next) begin
          check("done_after_last_pop", done, 1);
          done_next = 0;
        end
        if (stalled_prev) begin
          check("valid_held_while_stalled", do_valid, 1);
          check("data_held_while_stalled", do_data, held);
        end
        if (do_valid && do_ready) begin
          check("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check("stream_data", do_data, exp_q.pop_front());
            if (exp_q.size() == 0) done_next = 1;
          end
          pops++;
        end
        stalled_prev = do_valid && !do_ready;
        held = do_data;
      end
    end
  end

  // ---------------- ready driver ----------------
  // 0: always ready; 1: repeating 1,0,0,1,1,0; 2: random (~2/3 ready)
  int         rdy_mode = 0;
  logic [5:0] rdy_pat = 6'b011001;

  initial begin
    int idx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: do_ready = 1'b1;
        1: begin
          do_ready = rdy_pat[idx % 6];
          idx++;
        end
        default: do_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- driver tasks (called just after a posedge) ----------------
  task automatic start_xfer(input int b, input int l);
    start = 1'b1;
    base  = AW'(b);
    len   = (AW + 1)'(l);
    pops  = 0;
    model_load(b, l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_low_at_done"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NW; i++) mem[i] = DW'(i + 16);

    // reset state
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", do_valid, 0);
    check("rst_ram_addr", ram_addr, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // T1: BASE=3 LEN=5 full rate, exact cycle timing
    rdy_mode = 0;
    start = 1'b1; base = 4'd3; len = 5'd5; pops = 0;
    model_load(3, 5);
    @(negedge clk);
    check("t1_c0_busy", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_ram_addr", ram_addr, 3);
    check("t1_c1_valid", do_valid, 0);
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      check("t1_valid", do_valid, 1);
      check("t1_data", do_data, 32'h10 + 32'(c + 1));
      check("t1_busy", busy, 1);
      check("t1_done_low", done, 0);
    end
    @(negedge clk);
    check("t1_c7_done", done, 1);
    check("t1_c7_busy", busy, 0);
    check("t1_c7_valid", do_valid, 0);
    @(negedge clk);
    check("t1_c8_done", done, 0);
    check("t1_pops", pops, 5);
    @(posedge clk);
    #1;

    // T2: address wrap
    start_xfer(14, 4);
    wait_done("t2", 40);
    check("t2_pops", pops, 4);
    check("t2_q_empty", exp_q.size(), 0);

    // T3: backpressure pattern
    rdy_mode = 1;
    start_xfer(0, 6);
    wait_done("t3", 60);
    check("t3_pops", pops, 6);
    check("t3_q_empty", exp_q.size(), 0);
    rdy_mode = 0;

    // T4: LEN=0
    start = 1'b1; base = 4'd7; len = 5'd0; pops = 0;
    @(negedge clk);
    check("t4_c0_busy", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("t4_c1_done", done, 1);
    check("t4_c1_busy", busy, 0);
    check("t4_c1_valid", do_valid, 0);
    @(negedge clk);
    check("t4_c2_done", done, 0);
    check("t4_pops", pops, 0);
    @(posedge clk);
    #1;

    // T5: START while busy is ignored
    start_xfer(0, 8);
    @(posedge clk);
    #1;
    start = 1'b1; base = 4'd9; len = 5'd3;
    @(negedge clk);
    check("t5_busy_at_restart", busy, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5", 60);
    check("t5_pops", pops, 8);
    check("t5_q_empty", exp_q.size(), 0);

    // T6: reset mid-stream after two pops
    start_xfer(0, 8);
    begin
      int seen_pops = 0;
      for (int i = 0; i < 40 && seen_pops < 2; i++) begin
        @(negedge clk);
        if (do_valid && do_ready) seen_pops++;
      end
      check("t6_two_pops_seen", seen_pops, 2);
    end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("t6_valid_after_rst", do_valid, 0);
    check("t6_busy_after_rst", busy, 0);
    check("t6_done_after_rst", done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_done", done, 0);
      check("t6_no_valid", do_valid, 0);
    end
    @(posedge clk);
    #1;
    start_xfer(5, 1);
    wait_done("t6b", 20);
    check("t6b_pops", pops, 1);
    check("t6b_q_empty", exp_q.size(), 0);

    // Randomized: random RAM contents, bases, lengths and backpressure
    for (int i = 0; i < NW; i++) mem[i] = DW'($urandom);
    rdy_mode = 2;
    for (int t = 0; t < 14; t++) begin
      int b, l;
      b = $urandom_range(0, NW - 1);
      l = (t == 0) ? NW : (t == 1) ? 0 : $urandom_range(0, NW);
      if (t == 0) b = 7;
      start_xfer(b, l);
      wait_done("rnd", 8 * NW + 20);
      check("rnd_pops", pops, l);
      check("rnd_q_empty", exp_q.size(), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
